// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Multi-cycle controller for the four-operation lab ALU working on unsigned
// operands. Add and subtract finish in a single execute cycle. Multiply is an
// iterative shift-add (LSB first) and divide is restoring division (MSB first).
// Both iterative operations retire one bit per clock.
//
// The results feed the 7-segment display driver. For that reason every output
// register is written only on entry to DONE and then holds until the next
// operation completes.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   portA      : operand A (unsigned, W bits)
//   portB      : operand B (unsigned, W bits)
//   opcode     : 0=add, 1=sub, 2=mul, 3=div
//   start      : operation request, only honoured in IDLE
//   busy       : high from the cycle after start is accepted through DONE
//   done       : one-cycle completion pulse
//   result     : sum, |difference|, product or quotient (2W bits)
//   remainder  : division remainder (0 for non-divide opcodes)
//   signoresta : subtraction sign (A < B)
//   div_zero   : divide by zero flag
//
// W must be at least 2. The quotient shift register drops its MSB on every
// step.
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
    parameter int W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     portA,
    input  logic [W-1:0]     portB,
    input  logic [1:0]       opcode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   result,
    output logic [W-1:0]     remainder,
    output logic             signoresta,
    output logic             div_zero
);

    localparam int            CW        = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e         state_q,     state_d;
    logic [1:0]     op_q,        op_d;
    logic [W-1:0]   a_q,         a_d;         // A; becomes quotient shifter in div
    logic [W-1:0]   b_q,         b_d;         // B; shifted right as multiplier in mul
    logic [2*W-1:0] acc_q,       acc_d;       // product accumulator
    logic [2*W-1:0] mcand_q,     mcand_d;     // A << i for the current mul step
    logic [W-1:0]   rem_q,       rem_d;       // partial remainder in div
    logic [CW-1:0]  cnt_q,       cnt_d;
    logic           busy_q,      busy_d;
    logic           done_q,      done_d;
    logic [2*W-1:0] result_q,    result_d;
    logic [W-1:0]   remainder_q, remainder_d;
    logic           signo_q,     signo_d;
    logic           divz_q,      divz_d;

    logic [W:0]     add_sum_s;
    logic [W-1:0]   diff_ab_s;
    logic [W-1:0]   diff_ba_s;
    logic           a_ge_b_s;
    logic [2*W-1:0] acc_next_s;
    logic [W:0]     partial_s;
    logic [W:0]     trial_s;
    logic           qbit_s;
    logic [W-1:0]   rem_next_s;
    logic [W-1:0]   quot_next_s;
    logic           last_iter_s;
    logic           b_zero_s;

    // Datapath helpers shared by the execute step.
    assign add_sum_s   = {1'b0, a_q} + {1'b0, b_q};
    assign diff_ab_s   = a_q - b_q;
    assign diff_ba_s   = b_q - a_q;
    assign a_ge_b_s    = (a_q >= b_q);
    assign acc_next_s  = b_q[0] ? (acc_q + mcand_q) : acc_q;
    // Restoring step: bring the next dividend bit (a_q MSB) into the remainder.
    assign partial_s   = {rem_q, a_q[W-1]};
    assign trial_s     = partial_s - {1'b0, b_q};
    assign qbit_s      = ~trial_s[W];
    // A restored partial value is below B, so it always fits in W bits.
    assign rem_next_s  = trial_s[W] ? partial_s[W-1:0] : trial_s[W-1:0];
    assign quot_next_s = {a_q[W-2:0], qbit_s};
    assign last_iter_s = (cnt_q == LAST_ITER);
    assign b_zero_s    = (b_q == {W{1'b0}});

    // Next-state, datapath and output-register update logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        signo_d     = signo_q;
        divz_d      = divz_q;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_EXEC;
                    op_d    = opcode;
                    a_d     = portA;
                    b_d     = portB;
                    acc_d   = {(2*W){1'b0}};
                    mcand_d = {{W{1'b0}}, portA};
                    rem_d   = {W{1'b0}};
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        result_d    = {{(W-1){1'b0}}, add_sum_s};
                        remainder_d = {W{1'b0}};
                        signo_d     = 1'b0;
                        divz_d      = 1'b0;
                        state_d     = ST_DONE;
                    end

                    OP_SUB: begin
                        if (a_ge_b_s) begin
                            result_d = {{W{1'b0}}, diff_ab_s};
                            signo_d  = 1'b0;
                        end else begin
                            result_d = {{W{1'b0}}, diff_ba_s};
                            signo_d  = 1'b1;
                        end
                        remainder_d = {W{1'b0}};
                        divz_d      = 1'b0;
                        state_d     = ST_DONE;
                    end

                    OP_MUL: begin
                        acc_d   = acc_next_s;
                        mcand_d = mcand_q << 1;
                        b_d     = b_q >> 1;
                        if (last_iter_s) begin
                            result_d    = acc_next_s;
                            remainder_d = {W{1'b0}};
                            signo_d     = 1'b0;
                            divz_d      = 1'b0;
                            state_d     = ST_DONE;
                        end else begin
                            cnt_d   = cnt_q + CNT_ONE;
                            state_d = ST_EXEC;
                        end
                    end

                    OP_DIV: begin
                        if (b_zero_s) begin
                            // No iterations: saturated quotient, dividend as remainder.
                            result_d    = {{W{1'b0}}, {W{1'b1}}};
                            remainder_d = a_q;
                            signo_d     = 1'b0;
                            divz_d      = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            rem_d = rem_next_s;
                            a_d   = quot_next_s;
                            if (last_iter_s) begin
                                result_d    = {{W{1'b0}}, quot_next_s};
                                remainder_d = rem_next_s;
                                signo_d     = 1'b0;
                                divz_d      = 1'b0;
                                state_d     = ST_DONE;
                            end else begin
                                cnt_d   = cnt_q + CNT_ONE;
                                state_d = ST_EXEC;
                            end
                        end
                    end

                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // busy and done are registered from the next state so that they line up
        // with the state they describe.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= 2'd0;
            a_q         <= {W{1'b0}};
            b_q         <= {W{1'b0}};
            acc_q       <= {(2*W){1'b0}};
            mcand_q     <= {(2*W){1'b0}};
            rem_q       <= {W{1'b0}};
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= {(2*W){1'b0}};
            remainder_q <= {W{1'b0}};
            signo_q     <= 1'b0;
            divz_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            signo_q     <= signo_d;
            divz_q      <= divz_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign result     = result_q;
    assign remainder  = remainder_q;
    assign signoresta = signo_q;
    assign div_zero   = divz_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed bench for alu_op_sequencer with W=3. Expected values are worked out
// by hand. Inputs are driven and outputs sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

    localparam int W = 3;

    logic           clk;
    logic           rst;
    logic [W-1:0]   portA;
    logic [W-1:0]   portB;
    logic [1:0]     opcode;
    logic           start;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic [W-1:0]   remainder;
    logic           signoresta;
    logic           div_zero;

    int n_err;
    int n_chk;

    alu_op_sequencer #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .portA      (portA),
        .portB      (portB),
        .opcode     (opcode),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .remainder  (remainder),
        .signoresta (signoresta),
        .div_zero   (div_zero)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Present operands with start high for one edge. On return the bench sits
    // in cycle N+1.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] op);
        portA  = a;
        portB  = b;
        opcode = op;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // lat0 is the cycle offset from N at entry. Waits for done within a bound.
    task automatic wait_done(input string tag, input int lat0, input int exp_lat);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, exp_lat);
    endtask

    initial begin
        n_err  = 0;
        n_chk  = 0;
        rst    = 1'b0;
        start  = 1'b0;
        portA  = '0;
        portB  = '0;
        opcode = 2'd0;

        // Reset state.
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_sign", signoresta, 0);
        chk("rst_divz", div_zero, 0);
        rst = 1'b1;
        tick();

        // add 7+2.
        start_op(3'd7, 3'd2, 2'd0);
        chk("add_busy_n1", busy, 1);
        chk("add_done_n1", done, 0);
        portA = 3'd1;  // must not disturb the latched operands
        wait_done("add", 1, 2);
        chk("add_busy_n2", busy, 1);
        chk("add_result", result, 9);
        chk("add_sign", signoresta, 0);
        chk("add_remainder", remainder, 0);
        chk("add_divz", div_zero, 0);
        tick();
        chk("add_done_pulse", done, 0);
        chk("add_busy_after", busy, 0);
        chk("add_result_hold", result, 9);

        // sub 2-7 and 7-2.
        start_op(3'd2, 3'd7, 2'd1);
        wait_done("sub_neg", 1, 2);
        chk("sub_neg_result", result, 5);
        chk("sub_neg_sign", signoresta, 1);
        tick();
        start_op(3'd7, 3'd2, 2'd1);
        wait_done("sub_pos", 1, 2);
        chk("sub_pos_result", result, 5);
        chk("sub_pos_sign", signoresta, 0);
        tick();

        // mul 7*7 and 5*0.
        start_op(3'd7, 3'd7, 2'd2);
        chk("mul_busy_n1", busy, 1);
        wait_done("mul77", 1, 4);
        chk("mul77_result", result, 49);
        tick();
        start_op(3'd5, 3'd0, 2'd2);
        wait_done("mul50", 1, 4);
        chk("mul50_result", result, 0);
        tick();

        // div 7/2 and 5/0.
        start_op(3'd7, 3'd2, 2'd3);
        wait_done("div72", 1, 4);
        chk("div72_result", result, 3);
        chk("div72_remainder", remainder, 1);
        chk("div72_divz", div_zero, 0);
        tick();
        start_op(3'd6, 3'd3, 2'd3);
        wait_done("div63", 1, 4);
        chk("div63_result", result, 2);
        chk("div63_remainder", remainder, 0);
        tick();
        start_op(3'd5, 3'd0, 2'd3);
        wait_done("div50", 1, 2);
        chk("div50_result", result, 7);
        chk("div50_remainder", remainder, 5);
        chk("div50_divz", div_zero, 1);
        tick();

        // A start while busy is ignored, and the outputs then hold in idle.
        start_op(3'd7, 3'd7, 2'd2);
        portA  = 3'd1;
        portB  = 3'd1;
        opcode = 2'd0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done("mul_ign", 2, 4);
        chk("mul_ign_result", result, 49);
        chk("mul_ign_remainder", remainder, 0);
        chk("mul_ign_divz", div_zero, 0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_done", done, 0);
            chk("hold_busy", busy, 0);
            chk("hold_result", result, 49);
        end

        // Holding start high re-triggers on the first idle cycle after DONE.
        portA  = 3'd1;
        portB  = 3'd2;
        opcode = 2'd0;
        start  = 1'b1;
        tick();
        wait_done("rt1", 1, 2);
        chk("rt1_result", result, 3);
        portA = 3'd4;
        tick();
        chk("rt_idle_busy", busy, 0);
        tick();
        chk("rt2_busy", busy, 1);
        tick();
        chk("rt2_done", done, 1);
        chk("rt2_result", result, 6);
        start = 1'b0;
        tick();
        tick();

        // Reset during a multiply aborts it.
        start_op(3'd7, 3'd7, 2'd2);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_done", done, 0);
        tick();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", done, 0);
        end
        start_op(3'd3, 3'd3, 2'd0);
        wait_done("post_add", 1, 2);
        chk("post_add_result", result, 6);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Multi-cycle controller that sequences the 4-operation lab ALU (add, subtract, multiply, divide) on unsigned operands.
- Add/subtract are single-step.
- Multiply is iterative shift-add; divide is iterative restoring division, one bit per clock.
- Sits between the switch/opcode inputs and the 7-segment display driver, which consumes result, remainder and signoresta.
- Start/busy/done handshake.

Parameters:
W, 3, operand width in bits; iteration count for multiply/divide equals W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
rst  input  1  reset; one clock; reset is asynchronous and active-low.
portA  input  W  operand A (unsigned).
portB  input  W  operand B (unsigned).
opcode  input  2  0=add, 1=sub, 2=mul, 3=div.
start  input  1  operation request; sampled only in IDLE.
busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
done  output  1  one-cycle pulse; result, remainder and flags are valid from this cycle on.
result  output  2W  sum, |difference|, product, or quotient (zero-extended).
remainder  output  W  division remainder; 0 for other opcodes.
signoresta  output  1  1 when sub and A<B; else 0.
div_zero  output  1  1 when div and B=0; else 0.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0, done=0, result=0, remainder=0, signoresta=0, div_zero=0.
  - Iteration counter and internal operand/accumulator registers cleared.
  - Reset mid-operation aborts it; no done pulse is produced.
- States are IDLE, EXEC, DONE.
- IDLE:
  - When start=1 at an edge, latch portA, portB and opcode; clear the accumulator and counter; go to EXEC.
  - Inputs may change afterwards without effect.
  - start=0 stays in IDLE.
- EXEC, opcode 0 (add): result = A+B (W+1 bits, zero-extended); go to DONE after 1 cycle.
- EXEC, opcode 1 (sub):
  - A>=B: result = A-B, signoresta=0.
  - A<B: result = B-A, signoresta=1.
  - Go to DONE after 1 cycle.
- EXEC, opcode 2 (mul):
  - W iterations, one per cycle, LSB-first.
  - If multiplier bit i is 1, add A<<i to the accumulator.
  - After iteration W-1, go to DONE. Product max (2^W-1)^2 fits in 2W bits; no overflow.
- EXEC, opcode 3 (div):
  - W iterations of restoring division, MSB-first: shift the partial remainder left, bring in the next dividend bit, trial-subtract B.
  - Non-negative trial: keep it, quotient bit=1. Negative trial: restore, quotient bit=0.
  - After W iterations, go to DONE.
- Division by zero (B=0):
  - No iterations; go from EXEC to DONE after 1 cycle.
  - result = all ones in the low W bits (2^W-1), remainder=A, div_zero=1.
- DONE: done=1 and busy=1 for exactly one cycle; then IDLE unconditionally.
- Latency from the edge that accepts start (cycle N):
  - add, sub, div-by-zero: done at N+2.
  - mul, div: done at N+W+1 (N+4 for W=3).
- Output update timing:
  - result, remainder, signoresta and div_zero update only on entry to DONE.
  - They hold their values through IDLE until the next operation's DONE; the display stays stable.
  - Flags not relevant to the current opcode are written 0 at DONE.
- Handshake:
  - start while busy=1 (EXEC or DONE) is ignored; no queuing.
  - start held high continuously re-triggers on the first IDLE cycle after DONE.
- Counter: log2(W)+1 bits; never wraps within an operation.

Test Plan:
- Reset low, then release; A=7, B=2, op=0, start pulse at N -> done at N+2, result=9, signoresta=0, remainder=0, busy high at N+1..N+2.
- A=2, B=7, op=1 -> result=5, signoresta=1. Then A=7, B=2, op=1 -> result=5, signoresta=0.
- A=7, B=7, op=2, start at N -> done at N+4, result=49. Also A=5, B=0 -> result=0.
- A=7, B=2, op=3 -> done at N+4, result=3, remainder=1, div_zero=0. Then A=5, B=0 -> done at N+2, result=7, remainder=5, div_zero=1.
- Start A=7, B=7, op=2; re-pulse start with op=0 at N+2 -> ignored, done only at N+4 with result=49. Outputs then hold for 10 idle cycles.
- Start mul; assert rst=0 at N+2 -> all outputs 0 immediately, no done pulse. After release, a fresh add 3+3 -> result=6 at N'+2.
